// File: rtl/bus_driver_lectura.sv
// Read-side bus driver: decodes the processor read address, aligns the selection with
// the one-cycle RAM latency, returns the selected word, pops side-effect peripherals.
module bus_driver_lectura #(
    parameter logic [31:0] RAM_FIRST = 32'h0000_1000,
    parameter logic [31:0] RAM_LAST  = 32'h0000_13FC,
    parameter logic [31:0] ERR_DATA  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] address_i,
    input  logic        re_i,
    input  logic [31:0] data_ram_i,
    input  logic [31:0] data_teclado_ctrl_i,
    input  logic [31:0] data_teclado_i,
    input  logic [31:0] data_led_i,
    input  logic [31:0] data_7seg_i,
    input  logic [31:0] data_timer_i,
    input  logic [31:0] data_bcd_i,
    input  logic [31:0] data_bcd_reversed_i,
    input  logic [31:0] data_ctrl_uart_i,
    input  logic [31:0] data_data_uart_i,
    input  logic [31:0] data_ctrl_spi_i,
    input  logic        clr_err_i,
    output logic [31:0] data_o,
    output logic        rvalid_o,
    output logic        re_teclado_o,
    output logic        re_data_uart_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    localparam logic [31:0] ADDR_TECLADO_CTRL = 32'h0000_2000;
    localparam logic [31:0] ADDR_TECLADO      = 32'h0000_2004;
    localparam logic [31:0] ADDR_LED          = 32'h0000_2008;
    localparam logic [31:0] ADDR_7SEG         = 32'h0000_200C;
    localparam logic [31:0] ADDR_TIMER        = 32'h0000_2010;
    localparam logic [31:0] ADDR_BCD          = 32'h0000_2014;
    localparam logic [31:0] ADDR_BCD_REV      = 32'h0000_2018;
    localparam logic [31:0] ADDR_CTRL_UART    = 32'h0000_2020;
    localparam logic [31:0] ADDR_DATA_UART    = 32'h0000_2024;
    localparam logic [31:0] ADDR_CTRL_SPI     = 32'h0000_2100;

    typedef enum logic [3:0] {
        SEL_NONE         = 4'd0,
        SEL_RAM          = 4'd1,
        SEL_TECLADO_CTRL = 4'd2,
        SEL_TECLADO      = 4'd3,
        SEL_LED          = 4'd4,
        SEL_7SEG         = 4'd5,
        SEL_TIMER        = 4'd6,
        SEL_BCD          = 4'd7,
        SEL_BCD_REV      = 4'd8,
        SEL_CTRL_UART    = 4'd9,
        SEL_DATA_UART    = 4'd10,
        SEL_CTRL_SPI     = 4'd11,
        SEL_UNMAPPED     = 4'd12
    } sel_e;

    // A misaligned address inside the RAM window falls through to the peripheral
    // match and therefore ends up unmapped.
    function automatic sel_e decode_addr(input logic [31:0] addr);
        sel_e sel;
        if ((addr >= RAM_FIRST) && (addr <= RAM_LAST) && (addr[1:0] == 2'b00)) begin
            sel = SEL_RAM;
        end else begin
            case (addr)
                ADDR_TECLADO_CTRL: sel = SEL_TECLADO_CTRL;
                ADDR_TECLADO:      sel = SEL_TECLADO;
                ADDR_LED:          sel = SEL_LED;
                ADDR_7SEG:         sel = SEL_7SEG;
                ADDR_TIMER:        sel = SEL_TIMER;
                ADDR_BCD:          sel = SEL_BCD;
                ADDR_BCD_REV:      sel = SEL_BCD_REV;
                ADDR_CTRL_UART:    sel = SEL_CTRL_UART;
                ADDR_DATA_UART:    sel = SEL_DATA_UART;
                ADDR_CTRL_SPI:     sel = SEL_CTRL_SPI;
                default:           sel = SEL_UNMAPPED;
            endcase
        end
        return sel;
    endfunction

    sel_e        sel_q, sel_d;
    logic        rvalid_q, rvalid_d;
    logic        re_teclado_q, re_teclado_d;
    logic        re_data_uart_q, re_data_uart_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;
    sel_e        dec_sel_s;
    logic        unmapped_s;
    logic [31:0] data_s;

    // Address decode and next-state for the selection pipeline and pop strobes.
    always_comb begin
        dec_sel_s      = SEL_NONE;
        sel_d          = SEL_NONE;
        rvalid_d       = 1'b0;
        re_teclado_d   = 1'b0;
        re_data_uart_d = 1'b0;
        unmapped_s     = 1'b0;
        if (re_i) begin
            dec_sel_s      = decode_addr(address_i);
            sel_d          = dec_sel_s;
            rvalid_d       = 1'b1;
            re_teclado_d   = (dec_sel_s == SEL_TECLADO);
            re_data_uart_d = (dec_sel_s == SEL_DATA_UART);
            unmapped_s     = (dec_sel_s == SEL_UNMAPPED);
        end else begin
            dec_sel_s = SEL_NONE;
        end
    end

    // Sticky error next-state: a new unmapped read beats a coincident clear.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (unmapped_s) begin
            if (!err_q || clr_err_i) begin
                err_d      = 1'b1;
                err_addr_d = address_i;
            end else begin
                err_d      = err_q;
                err_addr_d = err_addr_q;
            end
        end else if (clr_err_i) begin
            err_d      = 1'b0;
            err_addr_d = 32'h0000_0000;
        end else begin
            err_d      = err_q;
            err_addr_d = err_addr_q;
        end
    end

    // State registers; reset drops any read already in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q          <= SEL_NONE;
            rvalid_q       <= 1'b0;
            re_teclado_q   <= 1'b0;
            re_data_uart_q <= 1'b0;
            err_q          <= 1'b0;
            err_addr_q     <= 32'h0000_0000;
        end else begin
            sel_q          <= sel_d;
            rvalid_q       <= rvalid_d;
            re_teclado_q   <= re_teclado_d;
            re_data_uart_q <= re_data_uart_d;
            err_q          <= err_d;
            err_addr_q     <= err_addr_d;
        end
    end

    // Return mux samples the peripheral words live in the cycle after the request.
    always_comb begin
        data_s = 32'h0000_0000;
        case (sel_q)
            SEL_NONE:         data_s = 32'h0000_0000;
            SEL_RAM:          data_s = data_ram_i;
            SEL_TECLADO_CTRL: data_s = data_teclado_ctrl_i;
            SEL_TECLADO:      data_s = data_teclado_i;
            SEL_LED:          data_s = data_led_i;
            SEL_7SEG:         data_s = data_7seg_i;
            SEL_TIMER:        data_s = data_timer_i;
            SEL_BCD:          data_s = data_bcd_i;
            SEL_BCD_REV:      data_s = data_bcd_reversed_i;
            SEL_CTRL_UART:    data_s = data_ctrl_uart_i;
            SEL_DATA_UART:    data_s = data_data_uart_i;
            SEL_CTRL_SPI:     data_s = data_ctrl_spi_i;
            SEL_UNMAPPED:     data_s = ERR_DATA;
            default:          data_s = 32'h0000_0000;
        endcase
    end

    assign data_o         = data_s;
    assign rvalid_o       = rvalid_q;
    assign re_teclado_o   = re_teclado_q;
    assign re_data_uart_o = re_data_uart_q;
    assign err_o          = err_q;
    assign err_addr_o     = err_addr_q;

endmodule

// File: tb/tb_bus_driver_lectura.sv
// Self-checking bench for bus_driver_lectura: directed scenarios plus random reads
// checked against an address-map reference model.
module tb_bus_driver_lectura;

    localparam logic [31:0] PADDR [10] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2010,
                                           32'h2014, 32'h2018, 32'h2020, 32'h2024, 32'h2100};

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] address_i;
    logic        re_i;
    logic        clr_err_i;
    logic [31:0] ram_data;
    logic [31:0] pdata [10];
    logic [31:0] data_o, err_addr_o;
    logic        rvalid_o, re_teclado_o, re_data_uart_o, err_o;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic        prev_re;
    logic [31:0] prev_addr;
    logic        m_err;
    logic [31:0] m_err_addr;
    logic        exp_rvalid, exp_tecl, exp_uart, exp_err;
    logic [31:0] exp_data, exp_err_addr;

    always #5 clk = ~clk;

    bus_driver_lectura dut (
        .clk_i(clk), .rst_i(rst_i), .address_i(address_i), .re_i(re_i),
        .data_ram_i(ram_data),
        .data_teclado_ctrl_i(pdata[0]), .data_teclado_i(pdata[1]), .data_led_i(pdata[2]),
        .data_7seg_i(pdata[3]), .data_timer_i(pdata[4]), .data_bcd_i(pdata[5]),
        .data_bcd_reversed_i(pdata[6]), .data_ctrl_uart_i(pdata[7]),
        .data_data_uart_i(pdata[8]), .data_ctrl_spi_i(pdata[9]),
        .clr_err_i(clr_err_i), .data_o(data_o), .rvalid_o(rvalid_o),
        .re_teclado_o(re_teclado_o), .re_data_uart_o(re_data_uart_o),
        .err_o(err_o), .err_addr_o(err_addr_o)
    );

    function automatic bit is_ram(input logic [31:0] a);
        return (a >= 32'h1000) && (a <= 32'h13FC) && (a % 4 == 0);
    endfunction

    function automatic bit is_mapped(input logic [31:0] a);
        if (is_ram(a)) return 1'b1;
        foreach (PADDR[i]) if (a == PADDR[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (is_ram(a)) return ram_data;
        foreach (PADDR[i]) if (a == PADDR[i]) return pdata[i];
        return 32'h0;
    endfunction

    task automatic model_reset();
        prev_re = 1'b0; prev_addr = 32'h0; m_err = 1'b0; m_err_addr = 32'h0;
    endtask

    // apply one cycle of request, then compute expectations at the falling edge
    task automatic drive(input logic re, input logic [31:0] addr, input logic clr);
        re_i = re; address_i = addr; clr_err_i = clr;
        @(negedge clk);
        exp_rvalid   = prev_re;
        exp_data     = prev_re ? model_read(prev_addr) : 32'h0;
        exp_tecl     = prev_re && (prev_addr == 32'h2004);
        exp_uart     = prev_re && (prev_addr == 32'h2024);
        exp_err      = m_err;
        exp_err_addr = m_err_addr;
    endtask

    task automatic advance();
        if (re_i && !is_mapped(address_i)) begin
            if (!m_err || clr_err_i) begin m_err = 1'b1; m_err_addr = address_i; end
        end else if (clr_err_i) begin
            m_err = 1'b0; m_err_addr = 32'h0;
        end
        prev_re = re_i; prev_addr = address_i;
        @(posedge clk); #1;
    endtask

    task automatic randomize_data();
        ram_data = $urandom;
        foreach (pdata[i]) pdata[i] = $urandom;
    endtask

    task automatic test_reset();
        n_cmp += 6;
        if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %0b expected 0", rvalid_o); end
        if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", data_o); end
        if (re_teclado_o !== 1'b0) begin n_err++; $display("FAIL reset_tecl: got %0b expected 0", re_teclado_o); end
        if (re_data_uart_o !== 1'b0) begin n_err++; $display("FAIL reset_uart: got %0b expected 0", re_data_uart_o); end
        if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b expected 0", err_o); end
        if (err_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_err_addr: got %h expected 0", err_addr_o); end
    endtask

    task automatic test_ram();
        drive(1'b1, 32'h13FC, 1'b0); advance();
        ram_data = 32'hCAFE0001;
        drive(1'b0, 32'h0, 1'b0);
        n_cmp += 2;
        if (data_o !== exp_data) begin n_err++; $display("FAIL ram_data: got %h expected %h", data_o, exp_data); end
        if (rvalid_o !== exp_rvalid) begin n_err++; $display("FAIL ram_rvalid: got %0b expected %0b", rvalid_o, exp_rvalid); end
        advance();
        drive(1'b1, 32'h1400, 1'b0);
        n_cmp++;
        if (rvalid_o !== exp_rvalid) begin n_err++; $display("FAIL ram_rvalid_once: got %0b expected %0b", rvalid_o, exp_rvalid); end
        advance();
        drive(1'b0, 32'h0, 1'b0);
        n_cmp += 4;
        if (data_o !== exp_data) begin n_err++; $display("FAIL ram_oob_data: got %h expected %h", data_o, exp_data); end
        if (rvalid_o !== exp_rvalid) begin n_err++; $display("FAIL ram_oob_rvalid: got %0b expected %0b", rvalid_o, exp_rvalid); end
        if (err_o !== exp_err) begin n_err++; $display("FAIL ram_oob_err: got %0b expected %0b", err_o, exp_err); end
        if (err_addr_o !== exp_err_addr) begin n_err++; $display("FAIL ram_oob_err_addr: got %h expected %h", err_addr_o, exp_err_addr); end
        advance();
    endtask

    task automatic test_sweep();
        foreach (pdata[i]) pdata[i] = PADDR[i];
        for (int i = 0; i <= 10; i++) begin
            drive(i < 10, (i < 10) ? PADDR[i % 10] : 32'h0, 1'b0);
            n_cmp += 2;
            if (data_o !== exp_data) begin n_err++; $display("FAIL sweep_data[%0d]: got %h expected %h", i, data_o, exp_data); end
            if (rvalid_o !== exp_rvalid) begin n_err++; $display("FAIL sweep_rvalid[%0d]: got %0b expected %0b", i, rvalid_o, exp_rvalid); end
            advance();
        end
    endtask

    task automatic test_back_to_back_pops();
        logic [31:0] seq [6];
        seq = '{32'h2024, 32'h2024, 32'h2004, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            randomize_data();
            drive(i < 3, seq[i], 1'b0);
            n_cmp += 3;
            if (re_data_uart_o !== exp_uart) begin n_err++; $display("FAIL pop_uart[%0d]: got %0b expected %0b", i, re_data_uart_o, exp_uart); end
            if (re_teclado_o !== exp_tecl) begin n_err++; $display("FAIL pop_tecl[%0d]: got %0b expected %0b", i, re_teclado_o, exp_tecl); end
            if (data_o !== exp_data) begin n_err++; $display("FAIL pop_data[%0d]: got %h expected %h", i, data_o, exp_data); end
            advance();
        end
    endtask

    task automatic test_sticky_error();
        logic [31:0] a [7];
        logic        r [7];
        logic        c [7];
        a = '{32'h0, 32'h3000, 32'h1002, 32'h2200, 32'h0, 32'h0, 32'h0};
        r = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        c = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(r[i], a[i], c[i]);
            n_cmp += 3;
            if (err_o !== exp_err) begin n_err++; $display("FAIL sticky_err[%0d]: got %0b expected %0b", i, err_o, exp_err); end
            if (err_addr_o !== exp_err_addr) begin n_err++; $display("FAIL sticky_addr[%0d]: got %h expected %h", i, err_addr_o, exp_err_addr); end
            if (data_o !== exp_data) begin n_err++; $display("FAIL sticky_data[%0d]: got %h expected %h", i, data_o, exp_data); end
            advance();
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            randomize_data();
            drive(1'b0, 32'h2024, 1'b0);
            n_cmp += 5;
            if (rvalid_o !== exp_rvalid) begin n_err++; $display("FAIL idle_rvalid[%0d]: got %0b expected %0b", i, rvalid_o, exp_rvalid); end
            if (data_o !== exp_data) begin n_err++; $display("FAIL idle_data[%0d]: got %h expected %h", i, data_o, exp_data); end
            if (re_data_uart_o !== exp_uart) begin n_err++; $display("FAIL idle_uart[%0d]: got %0b expected %0b", i, re_data_uart_o, exp_uart); end
            if (re_teclado_o !== exp_tecl) begin n_err++; $display("FAIL idle_tecl[%0d]: got %0b expected %0b", i, re_teclado_o, exp_tecl); end
            if (err_o !== exp_err) begin n_err++; $display("FAIL idle_err[%0d]: got %0b expected %0b", i, err_o, exp_err); end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            randomize_data();
            case ($urandom_range(3, 0))
                0: a = PADDR[$urandom_range(9, 0)];
                1: a = 32'h1000 + (32'($urandom_range(255, 0)) << 2);
                2: a = 32'h0FF0 + 32'($urandom_range(1056, 0));
                default: a = $urandom;
            endcase
            drive($urandom_range(3, 0) != 0, a, $urandom_range(9, 0) == 0);
            n_cmp += 6;
            if (rvalid_o !== exp_rvalid) begin n_err++; $display("FAIL rand_rvalid[%0d]: got %0b expected %0b", i, rvalid_o, exp_rvalid); end
            if (data_o !== exp_data) begin n_err++; $display("FAIL rand_data[%0d]: got %h expected %h", i, data_o, exp_data); end
            if (re_teclado_o !== exp_tecl) begin n_err++; $display("FAIL rand_tecl[%0d]: got %0b expected %0b", i, re_teclado_o, exp_tecl); end
            if (re_data_uart_o !== exp_uart) begin n_err++; $display("FAIL rand_uart[%0d]: got %0b expected %0b", i, re_data_uart_o, exp_uart); end
            if (err_o !== exp_err) begin n_err++; $display("FAIL rand_err[%0d]: got %0b expected %0b", i, err_o, exp_err); end
            if (err_addr_o !== exp_err_addr) begin n_err++; $display("FAIL rand_err_addr[%0d]: got %h expected %h", i, err_addr_o, exp_err_addr); end
            advance();
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 32'h3004, 1'b0); advance();
        drive(1'b1, 32'h2024, 1'b0); advance();
        // one step past the edge the pop strobe is already out; reset must kill it
        n_cmp++;
        if (re_data_uart_o !== (prev_re && prev_addr == 32'h2024)) begin
            n_err++; $display("FAIL mid_pre_uart: got %0b expected 1", re_data_uart_o);
        end
        rst_i = 1'b1;
        #1;
        test_reset();
        model_reset();
        #1 rst_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        n_cmp += 2;
        if (rvalid_o !== exp_rvalid) begin n_err++; $display("FAIL mid_post_rvalid: got %0b expected %0b", rvalid_o, exp_rvalid); end
        if (re_data_uart_o !== exp_uart) begin n_err++; $display("FAIL mid_post_uart: got %0b expected %0b", re_data_uart_o, exp_uart); end
        advance();
    endtask

    initial begin
        rst_i = 1'b1; re_i = 1'b0; address_i = 32'h0; clr_err_i = 1'b0;
        ram_data = 32'h0;
        foreach (pdata[i]) pdata[i] = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #2 rst_i = 1'b0;
        test_ram();
        test_sweep();
        test_back_to_back_pops();
        test_sticky_error();
        test_idle();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
